// File: rtl/tile_reg_file_pkg.sv
// Shared constants, register index map and byte-merge helper for the tile layer register file.
package tile_reg_file_pkg;

  localparam int unsigned NUM_TILE_LAYERS             = 4;
  localparam int unsigned NUM_TILE_REGISTERS          = 8;
  localparam int unsigned REG_DATA_WIDTH              = 16;
  localparam int unsigned ADDR_WIDTH                  = 5;
  localparam int unsigned NUM_TILE_SLOTS              = NUM_TILE_LAYERS * NUM_TILE_REGISTERS;
  localparam int unsigned NUM_REG_BITS_PER_TILE_LAYER = NUM_TILE_REGISTERS * REG_DATA_WIDTH;
  localparam int unsigned NUM_TOTAL_TILE_REG_BITS     = NUM_TILE_LAYERS * NUM_REG_BITS_PER_TILE_LAYER;

  typedef enum logic [2:0] {
    TileCtrl0      = 3'd0,
    TileCtrl1      = 3'd1,
    TileDataOffset = 3'd2,
    TileNopValue   = 3'd3,
    TileColorKey   = 3'd4,
    TileOffsetX    = 3'd5,
    TileOffsetY    = 3'd6,
    TileReserved   = 3'd7
  } tile_reg_e;

  // Per-byte merge; a clear be bit keeps the old byte.
  function automatic logic [REG_DATA_WIDTH-1:0] byte_merge(
    input logic [REG_DATA_WIDTH-1:0] old_val,
    input logic [REG_DATA_WIDTH-1:0] new_val,
    input logic [1:0]                be
  );
    logic [REG_DATA_WIDTH-1:0] res;
    res[15:8] = be[1] ? new_val[15:8] : old_val[15:8];
    res[7:0]  = be[0] ? new_val[7:0]  : old_val[7:0];
    return res;
  endfunction

endpackage

// File: rtl/tile_reg_file_if.sv
// CPU bus port of the tile register file: strobes, byte enables, address and data.
interface tile_reg_file_if;
  import tile_reg_file_pkg::*;

  logic                      en;
  logic                      rd;
  logic                      wr;
  logic [1:0]                be;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [REG_DATA_WIDTH-1:0] data_in;
  logic [REG_DATA_WIDTH-1:0] data_out;

  modport master (
    output en, rd, wr, be, addr, data_in,
    input  data_out
  );

  modport slave (
    input  en, rd, wr, be, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/tile_reg_cell.sv
// One double-buffered tile register: pending bank written by the CPU, active bank loaded on commit.
module tile_reg_cell
  import tile_reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wr,
  input  logic [1:0]                i_be,
  input  logic [REG_DATA_WIDTH-1:0] i_data,
  input  logic                      i_commit,
  input  logic                      i_immediate,
  output logic [REG_DATA_WIDTH-1:0] o_pending,
  output logic [REG_DATA_WIDTH-1:0] o_active
);

  logic [REG_DATA_WIDTH-1:0] r_pending;
  logic [REG_DATA_WIDTH-1:0] r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      if (i_wr) begin
        r_pending <= byte_merge(r_pending, i_data, i_be);
      end
      // Commit snapshots pre-write pending; an immediate write is merged on top of it.
      if (i_commit) begin
        if (i_wr && i_immediate) begin
          r_active <= byte_merge(r_pending, i_data, i_be);
        end else begin
          r_active <= r_pending;
        end
      end else if (i_wr && i_immediate) begin
        r_active <= byte_merge(r_active, i_data, i_be);
      end
    end
  end

  assign o_pending = r_pending;
  assign o_active  = r_active;

endmodule

// File: rtl/tile_reg_file.sv
// Tile layer register file: address decode, registered read mux, dirty flag and packed export.
module tile_reg_file
  import tile_reg_file_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  tile_reg_file_if.slave                     io_bus,
  input  logic                               i_commit,
  input  logic                               i_immediate,
  output logic                               o_dirty,
  output logic [NUM_TOTAL_TILE_REG_BITS-1:0] o_reg_values
);

  logic                      w_wr;
  logic                      w_rd;
  logic                      w_slot_ok;
  logic                      w_buffered_wr;
  logic [REG_DATA_WIDTH-1:0] w_pending [NUM_TILE_SLOTS];
  logic [REG_DATA_WIDTH-1:0] w_active  [NUM_TILE_SLOTS];
  logic                      r_dirty;
  logic [REG_DATA_WIDTH-1:0] r_data_out;

  assign w_wr          = io_bus.en & io_bus.wr;
  assign w_rd          = io_bus.en & io_bus.rd & ~io_bus.wr;
  assign w_slot_ok     = (io_bus.addr[2:0] != TileReserved);
  assign w_buffered_wr = w_wr & w_slot_ok & ~i_immediate;

  for (genvar gi = 0; gi < NUM_TILE_SLOTS; gi++) begin : g_slot
    if ((gi % NUM_TILE_REGISTERS) == int'(TileReserved)) begin : g_rsvd
      assign w_pending[gi] = '0;
      assign w_active[gi]  = '0;
    end else begin : g_cell
      tile_reg_cell u_cell (
        .clk         (clk),
        .reset       (reset),
        .i_wr        (w_wr && (io_bus.addr == ADDR_WIDTH'(gi))),
        .i_be        (io_bus.be),
        .i_data      (io_bus.data_in),
        .i_commit    (i_commit),
        .i_immediate (i_immediate),
        .o_pending   (w_pending[gi]),
        .o_active    (w_active[gi])
      );
    end
    assign o_reg_values[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = w_active[gi];
  end

  // Commit clears dirty unless a buffered write lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirty <= 1'b0;
    end else if (i_commit) begin
      r_dirty <= w_buffered_wr;
    end else if (w_buffered_wr) begin
      r_dirty <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (w_rd) begin
      r_data_out <= w_pending[io_bus.addr];
    end
  end

  assign o_dirty         = r_dirty;
  assign io_bus.data_out = r_data_out;

endmodule

// File: tb/tb_tile_reg_file.sv
// Directed bench for tile_reg_file: behavioural bank model plus a read-data scoreboard queue.
module tb_tile_reg_file;
  import tile_reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic commit = 1'b0;
  logic immediate = 1'b0;
  logic dirty;
  logic [NUM_TOTAL_TILE_REG_BITS-1:0] reg_values;

  tile_reg_file_if bus_if ();

  tile_reg_file dut (
    .clk          (clk),
    .reset        (reset),
    .io_bus       (bus_if),
    .i_commit     (commit),
    .i_immediate  (immediate),
    .o_dirty      (dirty),
    .o_reg_values (reg_values)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] m_pend [NUM_TILE_SLOTS];
  logic [15:0] m_act  [NUM_TILE_SLOTS];
  logic        m_dirty;
  logic [15:0] m_dout;
  logic [15:0] sb [$];

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[1]) r[15:8] = n[15:8];
    if (be[0]) r[7:0]  = n[7:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_TILE_SLOTS; i++) begin
      m_pend[i] = '0;
      m_act[i]  = '0;
    end
    m_dirty = 1'b0;
    m_dout  = '0;
    sb.delete();
  endtask

  task automatic chk_state(input string tag);
    logic [511:0] exp_vec;
    for (int i = 0; i < NUM_TILE_SLOTS; i++) exp_vec[i*16 +: 16] = m_act[i];
    chk({tag, ".reg_values"}, 512'(reg_values), exp_vec);
    chk({tag, ".dirty"}, 512'(dirty), 512'(m_dirty));
  endtask

  // One bus cycle; the model advances with the stimulus, reads are scored one cycle later.
  task automatic step(input logic rd, input logic wr, input logic [1:0] be,
                      input logic [4:0] a, input logic [15:0] d,
                      input logic cm, input logic imm);
    logic valid;
    logic [15:0] exp_rd;
    bus_if.en      = rd | wr;
    bus_if.rd      = rd;
    bus_if.wr      = wr;
    bus_if.be      = be;
    bus_if.addr    = a;
    bus_if.data_in = d;
    commit         = cm;
    immediate      = imm;
    if (rd && !wr) sb.push_back((a[2:0] == 3'd7) ? 16'h0 : m_pend[a]);
    valid = wr && (a[2:0] != 3'd7);
    if (cm) for (int i = 0; i < NUM_TILE_SLOTS; i++) m_act[i] = m_pend[i];
    if (valid) begin
      if (imm) m_act[a] = merge(m_act[a], d, be);
      m_pend[a] = merge(m_pend[a], d, be);
    end
    if (cm) m_dirty = valid && !imm;
    else if (valid && !imm) m_dirty = 1'b1;
    @(posedge clk);
    #1;
    bus_if.en = 1'b0;
    bus_if.rd = 1'b0;
    bus_if.wr = 1'b0;
    commit    = 1'b0;
    immediate = 1'b0;
    if (rd && !wr) begin
      exp_rd = sb.pop_front();
      m_dout = exp_rd;
      chk("read data", 512'(bus_if.data_out), 512'(exp_rd));
    end
  endtask

  initial begin
    bus_if.en = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    bus_if.be = 2'b00; bus_if.addr = '0; bus_if.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk_state("reset");
    chk("reset.data_out", 512'(bus_if.data_out), 512'h0);

    // Buffered write to layer 2 CTRL0, then read back the pending value
    step(0, 1, 2'b11, 5'd16, 16'h0401, 0, 0);
    chk_state("buffered write");
    step(1, 0, 2'b00, 5'd16, 16'h0000, 0, 0);

    step(0, 0, 2'b00, 5'd0, 16'h0000, 1, 0);
    chk_state("commit");
    step(0, 1, 2'b01, 5'd16, 16'hABCD, 0, 0);
    step(1, 0, 2'b00, 5'd16, 16'h0000, 0, 0);
    chk("byte merge", 512'(bus_if.data_out), 512'h04CD);

    // Write coinciding with commit stays pending only
    step(0, 1, 2'b11, 5'd13, 16'h1234, 1, 0);
    chk_state("write+commit");
    step(0, 0, 2'b00, 5'd0, 16'h0000, 1, 0);
    chk_state("second commit");

    step(0, 1, 2'b11, 5'd28, 16'h00FF, 0, 1);
    chk_state("immediate write");

    step(0, 1, 2'b11, 5'd7, 16'hFFFF, 0, 0);
    chk_state("reserved write");
    step(0, 0, 2'b00, 5'd0, 16'h0000, 1, 0);
    step(1, 0, 2'b00, 5'd7, 16'h0000, 0, 0);
    chk_state("reserved export");

    // Read and write together: write happens, data_out holds
    step(1, 0, 2'b00, 5'd13, 16'h0000, 0, 0);
    step(1, 1, 2'b10, 5'd13, 16'h9900, 0, 0);
    chk("rd+wr hold", 512'(bus_if.data_out), 512'(m_dout));
    step(1, 0, 2'b00, 5'd13, 16'h0000, 0, 0);

    step(0, 1, 2'b11, 5'd0, 16'h5A5A, 1, 1);
    chk_state("commit+immediate");

    // Asynchronous reset with dirty state and nonzero banks
    step(0, 1, 2'b11, 5'd30, 16'hBEEF, 0, 0);
    chk_state("pre-reset");
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk_state("async reset");
    chk("async reset.data_out", 512'(bus_if.data_out), 512'h0);
    @(posedge clk); #2 reset = 1'b0;

    step(0, 1, 2'b11, 5'd1, 16'h0F0F, 0, 0);
    step(1, 0, 2'b00, 5'd1, 16'h0000, 0, 0);
    chk_state("fresh start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
